// File: rtl/tower_pkg.sv
// tower_pkg: screen/tower geometry and spawn FSM state type shared by the falling-towers blocks
package tower_pkg;
  localparam int COORD_W  = 11;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int TOWER_W  = 28;
  localparam int TOWER_H  = 58;
  typedef enum logic [1:0] {S_IDLE, S_STEP, S_CHECK} spawn_state_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR (right shift, taps 16'hB400) with a lock-up-proof seed
module lfsr16 (
  input  logic        clk,
  input  logic        resetN,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = lfsr_q[0] ? (lfsr_q >> 1) ^ 16'hB400 : lfsr_q >> 1;
  // shift register; an all-zero seed would never leave zero, so it is replaced by 1
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) lfsr_q <= (seed == 16'h0000) ? 16'h0001 : seed;
    else if (en) lfsr_q <= lfsr_d;
  assign q = lfsr_q;
endmodule

// File: rtl/tower_spawn_x_gen.sv
// tower_spawn_x_gen: per-frame random tower spawn X with range/gap checks and a fallback
module tower_spawn_x_gen
  import tower_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          X_MIN     = 0,
  parameter int          X_MAX     = SCREEN_W - TOWER_W - 1,
  parameter int          X_INIT    = 300,
  parameter int          MIN_GAP   = 40,
  parameter int          MAX_TRIES = 8
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      pause,
  output logic signed [COORD_W-1:0] spawnX,
  output logic                      spawnValid,
  output logic [7:0]                spawnCount,
  output logic                      fallbackUsed
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  spawn_state_t              state_q, state_d;
  logic [TW-1:0]             tries_q, tries_d;
  logic signed [COORD_W-1:0] spawn_q, spawn_d, last_q, last_d;
  logic                      valid_q, valid_d, fb_q, fb_d;
  logic [7:0]                count_q, count_d;
  logic                      lfsr_en, accept, give_up, unused_lfsr;
  logic [15:0]               lfsr_q;
  int                        cand, last, gap, fb_x;
  lfsr16 u_lfsr (.clk(clk), .resetN(resetN), .en(lfsr_en), .seed(LFSR_SEED), .q(lfsr_q));
  assign unused_lfsr = ^lfsr_q[15:10];
  assign cand    = int'(lfsr_q[9:0]);
  assign last    = int'(last_q);
  assign gap     = cand >= last ? cand - last : last - cand;
  assign accept  = cand >= X_MIN && cand <= X_MAX && gap >= MIN_GAP;
  assign fb_x    = last + MIN_GAP <= X_MAX ? last + MIN_GAP : last - MIN_GAP;
  assign give_up = tries_q == TW'(MAX_TRIES);
  // state and result registers, all returned to their reset values asynchronously
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= S_IDLE;
      tries_q <= '0;
      spawn_q <= COORD_W'(X_INIT);
      last_q  <= COORD_W'(X_INIT);
      valid_q <= 1'b1;
      count_q <= '0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      spawn_q <= spawn_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      count_q <= count_d;
      fb_q    <= fb_d;
    end
  // search FSM: start only when unpaused, step/check until accept or the try budget runs out
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    spawn_d = spawn_q;
    last_d  = last_q;
    valid_d = valid_q;
    count_d = count_q;
    fb_d    = 1'b0;
    lfsr_en = 1'b0;
    case (state_q)
      S_IDLE: if (startOfFrame && !pause) begin
        state_d = S_STEP;
        tries_d = '0;
        valid_d = 1'b0;
      end
      S_STEP: begin
        lfsr_en = 1'b1;
        tries_d = tries_q + TW'(1);
        state_d = S_CHECK;
      end
      S_CHECK: if (accept || give_up) begin
        spawn_d = accept ? COORD_W'(cand) : COORD_W'(fb_x);
        last_d  = spawn_d;
        valid_d = 1'b1;
        count_d = count_q + 8'd1;
        fb_d    = !accept;
        state_d = S_IDLE;
      end else state_d = S_STEP;
      default: state_d = S_IDLE;
    endcase
  end
  assign spawnX       = spawn_q;
  assign spawnValid   = valid_q;
  assign spawnCount   = count_q;
  assign fallbackUsed = fb_q;
endmodule

// File: tb/tb_tower_spawn_x_gen.sv
// tb_tower_spawn_x_gen: randomized scoreboard bench against a frame-level reference model
module tb_tower_spawn_x_gen;
  typedef struct {int x; bit fb; int cnt; int prev;} exp_t;
  logic clk = 1'b0;
  logic rst_n, pause;
  logic [1:0] sof, vld;
  logic signed [10:0] x0, x1;
  logic v0, v1, f0, f1;
  logic [7:0] c0, c1;
  int checks = 0, passes = 0;
  exp_t q0[$], q1[$];
  logic [15:0] m_s[2];
  int m_last[2], m_cnt[2];
  int xmin[2] = '{0, 500};
  int xmax[2] = '{611, 500};
  int mgap[2] = '{40, 0};
  bit [1:0] mon_en;
  bit pv0 = 1'b0, pv1 = 1'b0;
  int first_x, xo;

  tower_spawn_x_gen u0 (.clk(clk), .resetN(rst_n), .startOfFrame(sof[0]), .pause(pause),
    .spawnX(x0), .spawnValid(v0), .spawnCount(c0), .fallbackUsed(f0));
  tower_spawn_x_gen #(.X_MIN(500), .X_MAX(500), .X_INIT(500), .MIN_GAP(0)) u1 (.clk(clk),
    .resetN(rst_n), .startOfFrame(sof[1]), .pause(1'b0),
    .spawnX(x1), .spawnValid(v1), .spawnCount(c1), .fallbackUsed(f1));

  assign vld = {v1, v0};
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? (s >> 1) ^ 16'hB400 : s >> 1;
  endfunction

  task automatic model_frame(inout logic [15:0] s, inout int last, input int lo, input int hi,
                             input int g, output int x, output bit fb, output int tries);
    int c;
    x = -1; fb = 0; tries = 0;
    while (x < 0 && tries < 8) begin
      tries++;
      s = lfsr_next(s);
      c = int'(s[9:0]);
      if (c >= lo && c <= hi && (c >= last ? c - last : last - c) >= g) x = c;
    end
    if (x < 0) begin
      fb = 1;
      x = (last + g <= hi) ? last + g : last - g;
    end
    last = x;
  endtask

  task automatic observe(input int d, input int x, input bit f, input int c);
    exp_t e;
    int n;
    n = d == 0 ? q0.size() : q1.size();
    chk("pending_expect", int'(n > 0), 1);
    if (n == 0) return;
    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
    chk("spawnX", x, e.x);
    chk("fallbackUsed", int'(f), int'(e.fb));
    chk("spawnCount", c, e.cnt);
    chk("in_range", int'(x >= xmin[d] && x <= xmax[d]), 1);
    if (!e.fb) chk("min_gap", int'((x >= e.prev ? x - e.prev : e.prev - x) >= mgap[d]), 1);
  endtask

  always @(negedge clk) begin
    if (mon_en[0] && v0 && !pv0) observe(0, int'(x0), f0, int'(c0));
    pv0 = v0;
  end
  always @(negedge clk) begin
    if (mon_en[1] && v1 && !pv1) observe(1, int'(x1), f1, int'(c1));
    pv1 = v1;
  end

  task automatic run_frame(input int d, input int extra, input bit rnd, output int xr);
    exp_t e;
    logic [15:0] s;
    int l, tries, done;
    bit fbm;
    s = m_s[d]; l = m_last[d];
    e.prev = l;
    model_frame(s, l, xmin[d], xmax[d], mgap[d], e.x, fbm, tries);
    m_s[d] = s; m_last[d] = l;
    e.fb = fbm;
    m_cnt[d] = (m_cnt[d] + 1) % 256;
    e.cnt = m_cnt[d];
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    xr = e.x;
    done = 0;
    pause = 1'b0;
    sof[d] = 1'b1;
    @(negedge clk);
    sof[d] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) chk("valid_low_cycle1", int'(vld[d]), 0);
      else if (vld[d]) begin done = k; break; end
      sof[d] = (k == extra) || (rnd && $urandom_range(0, 3) == 0);
      if (rnd) pause = 1'($urandom_range(0, 1));
    end
    sof[d] = 1'b0;
    pause = 1'b0;
    chk("latency", done, 2 * tries + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sof = '0; pause = 1'b0; mon_en = '0;
    m_s = '{16'hACE1, 16'hACE1}; m_last = '{300, 500}; m_cnt = '{0, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 2'b11;
    chk("rst_spawnX", int'(x0), 300);
    chk("rst_valid", int'(v0), 1);
    chk("rst_count", int'(c0), 0);
    chk("rst_fallback", int'(f0), 0);
    chk("rst_spawnX_u1", int'(x1), 500);
    repeat (10) @(negedge clk);
    chk("idle_spawnX", int'(x0), 300);
    chk("idle_valid", int'(v0), 1);
    chk("idle_count", int'(c0), 0);
    pause = 1'b1;
    repeat (5) begin
      sof[0] = 1'b1;
      @(negedge clk);
      sof[0] = 1'b0;
      chk("pause_valid", int'(v0), 1);
      @(negedge clk);
    end
    chk("pause_spawnX", int'(x0), 300);
    chk("pause_count", int'(c0), 0);
    pause = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        pause = 1'b1;
        sof[0] = 1'b1;
        @(negedge clk);
        sof[0] = 1'b0;
        @(negedge clk);
        pause = 1'b0;
      end
      run_frame(0, 0, 1'b1, xo);
      if (i == 0) first_x = xo;
    end
    chk("count_1000", int'(c0), 232);
    run_frame(1, 0, 1'b0, xo);
    chk("narrow_spawnX", int'(x1), 500);
    repeat (5) @(negedge clk);
    chk("narrow_valid_held", int'(v1), 1);
    run_frame(0, 2, 1'b0, xo);
    repeat (20) @(negedge clk);
    chk("single_increment", int'(c0), m_cnt[0]);
    chk("second_sof_valid", int'(v0), 1);
    mon_en = '0;
    sof[0] = 1'b1;
    @(negedge clk);
    sof[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_spawnX", int'(x0), 300);
    chk("async_rst_valid", int'(v0), 1);
    chk("async_rst_count", int'(c0), 0);
    chk("async_rst_fallback", int'(f0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete(); q1.delete();
    m_s = '{16'hACE1, 16'hACE1}; m_last = '{300, 500}; m_cnt = '{0, 0};
    @(negedge clk);
    mon_en = 2'b11;
    run_frame(0, 0, 1'b0, xo);
    chk("replay_first_frame", int'(x0), first_x);
    @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
